// File: rtl/amo_ctrl_if.sv
// amo_ctrl_if: request/response and data-memory bus bundle for the AMO sequencer
//   slave  : the controller side (amo_ctrl)
//   master : the pipeline + memory side (environment)
//   req_*      execute-stage AMO request handshake (op, addr=rs1, data=rs2)
//   resp_*     one-cycle result pulse (old value for rd, error flag)
//   busy       pipeline stall while a sequence is in flight
//   mem_req_*  data-memory request (valid/ready, we, addr, wdata, byte mask)
//   mem_rsp_*  data-memory read response (valid, rdata)
interface amo_ctrl_if #(parameter int DATA_WIDTH = 32);
  logic                    req_valid;
  logic                    req_ready;
  logic [3:0]              req_op;
  logic [DATA_WIDTH-1:0]   req_addr;
  logic [DATA_WIDTH-1:0]   req_data;
  logic                    resp_valid;
  logic [DATA_WIDTH-1:0]   resp_data;
  logic                    resp_err;
  logic                    busy;
  logic                    mem_req_valid;
  logic                    mem_req_ready;
  logic                    mem_req_we;
  logic [DATA_WIDTH-1:0]   mem_req_addr;
  logic [DATA_WIDTH-1:0]   mem_req_wdata;
  logic [DATA_WIDTH/8-1:0] mem_req_mask;
  logic                    mem_rsp_valid;
  logic [DATA_WIDTH-1:0]   mem_rsp_rdata;
  modport slave (
    input  req_valid, req_op, req_addr, req_data, mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
    output req_ready, resp_valid, resp_data, resp_err, busy,
           mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_mask
  );
  modport master (
    output req_valid, req_op, req_addr, req_data, mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
    input  req_ready, resp_valid, resp_data, resp_err, busy,
           mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_mask
  );
endinterface

// File: rtl/amo_ctrl.sv
// amo_ctrl: RV32A AMO*.W read-modify-write sequencer, one operation in flight
//   clk    : clock
//   arst_n : synchronous active-low reset
//   bus    : amo_ctrl_if.slave (request/response handshake + data-memory port)
//   Optional macro AMO_CTRL_LRSC_EN adds LR (op 9) / SC (op 10) and a reservation register.
module amo_ctrl #(
  parameter int DATA_WIDTH = 32
) (
  input logic       clk,
  input logic       arst_n,
  amo_ctrl_if.slave bus
);
  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SWAP = 4'd1;
  localparam logic [3:0] OP_XOR  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_MIN  = 4'd5;
  localparam logic [3:0] OP_MAX  = 4'd6;
  localparam logic [3:0] OP_MINU = 4'd7;
  localparam logic [3:0] OP_MAXU = 4'd8;

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, RESP} state_t;

  state_t                state, nxt;
  logic [3:0]            op_q;
  logic [DATA_WIDTH-1:0] addr_q, opd_q, old_q, new_q;
  logic                  err_q;
  logic                  acc, bad, legal, is_sc_req, sc_hit, lr_q, rsp_hit;
  logic                  lt_s, gt_s, lt_u, gt_u;
  logic [DATA_WIDTH-1:0] old_v, f_val;

`ifdef AMO_CTRL_LRSC_EN
  localparam logic [3:0] OP_LR = 4'd9;
  localparam logic [3:0] OP_SC = 4'd10;
  logic                  res_v;
  logic [DATA_WIDTH-1:0] res_a;
  assign legal     = bus.req_op <= OP_SC;
  assign is_sc_req = bus.req_op == OP_SC;
  assign sc_hit    = res_v && res_a == bus.req_addr;
  assign lr_q      = op_q == OP_LR;
`else
  assign legal     = bus.req_op <= OP_MAXU;
  assign is_sc_req = 1'b0;
  assign sc_hit    = 1'b0;
  assign lr_q      = 1'b0;
`endif

  assign acc     = state == IDLE && bus.req_valid;
  assign bad     = !legal || |bus.req_addr[1:0];
  assign rsp_hit = state == RD_WAIT && bus.mem_rsp_valid;
  assign old_v   = bus.mem_rsp_rdata;

  // Equal operands fall through to old in every min/max flavour.
  assign lt_s = $signed(opd_q) < $signed(old_v);
  assign gt_s = $signed(opd_q) > $signed(old_v);
  assign lt_u = opd_q < old_v;
  assign gt_u = opd_q > old_v;

  always_comb begin
    f_val = op_q == OP_ADD  ? old_v + opd_q :
            op_q == OP_SWAP ? opd_q :
            op_q == OP_XOR  ? old_v ^ opd_q :
            op_q == OP_AND  ? old_v & opd_q :
            op_q == OP_OR   ? old_v | opd_q :
            op_q == OP_MIN  ? (lt_s ? opd_q : old_v) :
            op_q == OP_MAX  ? (gt_s ? opd_q : old_v) :
            op_q == OP_MINU ? (lt_u ? opd_q : old_v) :
            op_q == OP_MAXU ? (gt_u ? opd_q : old_v) : old_v;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (bus.req_valid) nxt = bad ? RESP : is_sc_req ? (sc_hit ? WR_REQ : RESP) : RD_REQ;
      RD_REQ:  if (bus.mem_req_ready) nxt = RD_WAIT;
      RD_WAIT: if (bus.mem_rsp_valid) nxt = lr_q ? RESP : WR_REQ;
      WR_REQ:  if (bus.mem_req_ready) nxt = RESP;
      RESP:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state  <= IDLE;
      op_q   <= '0;
      addr_q <= '0;
      opd_q  <= '0;
      old_q  <= '0;
      new_q  <= '0;
      err_q  <= 1'b0;
`ifdef AMO_CTRL_LRSC_EN
      res_v  <= 1'b0;
      res_a  <= '0;
`endif
    end else begin
      state <= nxt;
      if (acc) begin
        op_q   <= bus.req_op;
        addr_q <= bus.req_addr;
        opd_q  <= bus.req_data;
        // SC writes its operand directly; a failed SC reports 1 through old_q.
        new_q  <= bus.req_data;
        err_q  <= bad;
        old_q  <= DATA_WIDTH'(!bad && is_sc_req && !sc_hit);
      end
      if (rsp_hit) begin
        old_q <= old_v;
        new_q <= f_val;
      end
`ifdef AMO_CTRL_LRSC_EN
      if (acc && !bad && is_sc_req) res_v <= 1'b0;
      if (rsp_hit && lr_q) begin
        res_v <= 1'b1;
        res_a <= addr_q;
      end
      if (state == WR_REQ && bus.mem_req_ready && addr_q == res_a) res_v <= 1'b0;
`endif
    end
  end

  // Handshake outputs are gated by reset so nothing is offered or accepted while it is held.
  assign bus.req_ready     = arst_n && state == IDLE;
  assign bus.busy          = arst_n && state != IDLE;
  assign bus.mem_req_valid = arst_n && (state == RD_REQ || state == WR_REQ);
  assign bus.mem_req_we    = arst_n && state == WR_REQ;
  assign bus.mem_req_addr  = addr_q;
  assign bus.mem_req_wdata = new_q;
  assign bus.mem_req_mask  = '1;
  assign bus.resp_valid    = arst_n && state == RESP;
  assign bus.resp_data     = old_q;
  assign bus.resp_err      = arst_n && state == RESP && err_q;
endmodule

// File: tb/tb_amo_ctrl.sv
// tb_amo_ctrl: randomized self-checking bench for amo_ctrl against a behavioural AMO model
module tb_amo_ctrl;
`ifdef AMO_CTRL_LRSC_EN
  localparam int LEGAL_MAX = 10;
`else
  localparam int LEGAL_MAX = 8;
`endif

  typedef struct {
    int          c;
    logic        rdy, bsy, v, we;
    logic [31:0] a, d;
  } tr_t;

  logic clk = 1'b0;
  logic arst_n = 1'b0;
  always #5 clk = ~clk;

  amo_ctrl_if #(.DATA_WIDTH(32)) bus();
  amo_ctrl #(.DATA_WIDTH(32)) dut (.clk(clk), .arst_n(arst_n), .bus(bus));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] mem [256];
  logic [31:0] ref_mem [256];
  bit          res_v = 0;
  logic [31:0] res_a = '0;

  int rd_stall = 0, wr_stall = 0, rsp_delay = 0;
  int rsp_timer = -1, scnt = 0;
  logic [31:0] rsp_buf;

  int rd_c[$], wr_c[$], rsp_c[$];
  logic [31:0] wr_a[$], wr_d[$], rsp_d[$];
  bit rsp_e[$];
  int mrv_cnt;
  tr_t trace[$];

  task automatic clear_logs();
    rd_c.delete(); wr_c.delete(); rsp_c.delete();
    wr_a.delete(); wr_d.delete(); rsp_d.delete(); rsp_e.delete();
    trace.delete(); mrv_cnt = 0;
  endtask

  // memory: stalls a configurable number of cycles per request, answers reads rsp_delay cycles later
  initial begin
    bus.mem_req_ready = 0; bus.mem_rsp_valid = 0; bus.mem_rsp_rdata = '0;
    forever begin
      @(posedge clk); #2;
      if (rsp_timer == 0) begin
        bus.mem_rsp_valid = 1; bus.mem_rsp_rdata = rsp_buf; rsp_timer = -1;
      end else begin
        bus.mem_rsp_valid = 0; bus.mem_rsp_rdata = $urandom;
        if (rsp_timer > 0) rsp_timer--;
      end
      if (bus.mem_req_valid) begin
        if (scnt < (bus.mem_req_we ? wr_stall : rd_stall)) begin
          bus.mem_req_ready = 0; scnt++;
        end else begin
          bus.mem_req_ready = 1; scnt = 0;
          if (bus.mem_req_we) mem[bus.mem_req_addr[9:2]] = bus.mem_req_wdata;
          else begin rsp_buf = mem[bus.mem_req_addr[9:2]]; rsp_timer = rsp_delay; end
        end
      end else begin
        bus.mem_req_ready = 1'($urandom_range(0, 1)); scnt = 0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      trace.push_back('{cyc, bus.req_ready, bus.busy, bus.mem_req_valid, bus.mem_req_we, bus.mem_req_addr, bus.mem_req_wdata});
      if (bus.mem_req_valid) mrv_cnt++;
      if (bus.mem_req_valid && bus.mem_req_ready) begin
        if (bus.mem_req_we) begin wr_c.push_back(cyc); wr_a.push_back(bus.mem_req_addr); wr_d.push_back(bus.mem_req_wdata); end
        else rd_c.push_back(cyc);
      end
      if (bus.resp_valid) begin rsp_c.push_back(cyc); rsp_d.push_back(bus.resp_data); rsp_e.push_back(bus.resp_err); end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] amo_f(input logic [3:0] op, input logic [31:0] o, input logic [31:0] d);
    int so = int'(o), sd = int'(d);
    longint uo = longint'({32'd0, o}), ud = longint'({32'd0, d});
    logic [63:0] sum = {32'd0, o} + {32'd0, d};
    case (op)
      4'd0: return sum[31:0];
      4'd1: return d;
      4'd2: return o ^ d;
      4'd3: return o & d;
      4'd4: return o | d;
      4'd5: return (sd < so) ? d : o;
      4'd6: return (sd > so) ? d : o;
      4'd7: return (ud < uo) ? d : o;
      default: return (ud > uo) ? d : o;
    endcase
  endfunction

  task automatic model_amo(input logic [3:0] op, input logic [31:0] a, input logic [31:0] d, input int rs, input int ws,
                           output bit e_err, output logic [31:0] e_data, output bit e_wr, output logic [31:0] e_wd, output int e_lat);
    int idx = int'(a[9:2]);
    e_err = 0; e_wr = 0; e_wd = '0; e_data = '0;
    if (int'(op) > LEGAL_MAX || a[1:0] != 2'b00) begin
      e_err = 1; e_lat = 1;
    end else if (op == 4'd9) begin
      e_data = ref_mem[idx]; res_v = 1; res_a = a; e_lat = 3 + rs;
    end else if (op == 4'd10) begin
      if (res_v && res_a == a) begin e_wr = 1; e_wd = d; ref_mem[idx] = d; e_lat = 2 + ws; end
      else begin e_data = 32'd1; e_lat = 1; end
      res_v = 0;
    end else begin
      e_data = ref_mem[idx]; e_wd = amo_f(op, e_data, d); e_wr = 1; ref_mem[idx] = e_wd; e_lat = 4 + rs + ws;
      if (res_v && res_a == a) res_v = 0;
    end
  endtask

  task automatic run_amo(input logic [3:0] op, input logic [31:0] a, input logic [31:0] d, input int rs, input int ws, output int t);
    clear_logs(); rd_stall = rs; wr_stall = ws; t = -1;
    @(posedge clk); #1;
    bus.req_valid = 1; bus.req_op = op; bus.req_addr = a; bus.req_data = d;
    for (int i = 0; i < 20 && t < 0; i++) begin @(negedge clk); if (bus.req_ready) t = cyc; end
    @(posedge clk); #1;
    bus.req_valid = 0; bus.req_op = 4'($urandom); bus.req_addr = $urandom; bus.req_data = $urandom;
    for (int i = 0; i < 40 && rsp_c.size() == 0; i++) begin @(negedge clk); #1; end
    repeat (2) @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if ({bus.req_ready, bus.resp_valid, bus.resp_err, bus.busy, bus.mem_req_valid, bus.mem_req_we} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 000000", {bus.req_ready, bus.resp_valid, bus.resp_err, bus.busy, bus.mem_req_valid, bus.mem_req_we}); end
    checks++; if ({bus.resp_data, bus.mem_req_addr, bus.mem_req_wdata} !== 96'd0) begin
      errors++; $display("FAIL reset_data: got %h expected 0", {bus.resp_data, bus.mem_req_addr, bus.mem_req_wdata}); end
    checks++; if (bus.mem_req_mask !== 4'hF) begin errors++; $display("FAIL reset_mask: got %h expected f", bus.mem_req_mask); end
    @(posedge clk); #1; arst_n = 1;
    @(negedge clk);
    checks++; if ({bus.req_ready, bus.busy} !== 2'b10) begin errors++; $display("FAIL reset_idle: ready/busy got %b expected 10", {bus.req_ready, bus.busy}); end
  endtask

  task automatic test_add();
    int t, lat; bit ee, ew; logic [31:0] ed, ewd;
    mem[64] = 32'd5; ref_mem[64] = 32'd5;
    model_amo(4'd0, 32'h100, 32'd3, 0, 0, ee, ed, ew, ewd, lat);
    run_amo(4'd0, 32'h100, 32'd3, 0, 0, t);
    checks++; if (rd_c.size() != 1 || rd_c[0] != t + 1) begin errors++; $display("FAIL add_read_cycle: got %0d reads, first at +%0d, expected 1 at +1", rd_c.size(), rd_c.size() ? rd_c[0] - t : -1); end
    checks++; if (wr_c.size() != 1 || wr_c[0] != t + 3) begin errors++; $display("FAIL add_write_cycle: got %0d writes, first at +%0d, expected 1 at +3", wr_c.size(), wr_c.size() ? wr_c[0] - t : -1); end
    checks++; if (wr_c.size() != 1 || wr_a[0] !== 32'h100 || wr_d[0] !== 32'd8) begin errors++; $display("FAIL add_write: got %0d writes, expected 8 to 0x100", wr_c.size()); end
    checks++; if (rsp_c.size() != 1 || rsp_c[0] != t + 4 || rsp_d[0] !== 32'd5 || rsp_e[0] !== 1'b0) begin
      errors++; $display("FAIL add_resp: got %0d responses, expected one at +4 with data 5 err 0", rsp_c.size()); end
  endtask

  task automatic test_minmax();
    int t, lat; bit ee, ew; logic [31:0] ed, ewd;
    for (int k = 0; k < 2; k++) begin
      logic [3:0] op = (k == 0) ? 4'd5 : 4'd7;
      logic [31:0] exp_w = (k == 0) ? 32'hFFFF_FFFF : 32'd1;
      mem[80] = 32'hFFFF_FFFF; ref_mem[80] = 32'hFFFF_FFFF;
      model_amo(op, 32'h140, 32'd1, 0, 0, ee, ed, ew, ewd, lat);
      run_amo(op, 32'h140, 32'd1, 0, 0, t);
      checks++; if (wr_c.size() != 1 || wr_d[0] !== exp_w) begin errors++; $display("FAIL minmax_write op%0d: got %0d writes data %h expected %h", op, wr_c.size(), wr_c.size() ? wr_d[0] : 32'hx, exp_w); end
      checks++; if (rsp_c.size() != 1 || rsp_d[0] !== 32'hFFFF_FFFF) begin errors++; $display("FAIL minmax_resp op%0d: got %0d responses, expected ffffffff", op, rsp_c.size()); end
    end
  endtask

  task automatic test_stall();
    int t, lat, hold = 0, stab = 0, nv = 0; bit ee, ew; logic [31:0] ed, ewd, d = $urandom;
    model_amo(4'd0, 32'h100, d, 3, 2, ee, ed, ew, ewd, lat);
    run_amo(4'd0, 32'h100, d, 3, 2, t);
    rd_stall = 0; wr_stall = 0;
    foreach (trace[i]) begin
      if (trace[i].c >= t + 1 && trace[i].c <= t + 9 && (trace[i].rdy || !trace[i].bsy)) hold++;
      if (trace[i].v && (trace[i].a !== 32'h100 || (trace[i].we && trace[i].d !== ewd) ||
          (!trace[i].we && trace[i].c > t + 4) || (trace[i].we && trace[i].c < t + 6))) stab++;
      if (trace[i].v) nv++;
    end
    checks++; if (rsp_c.size() != 1 || rsp_c[0] != t + 9 || rsp_d[0] !== ed) begin errors++; $display("FAIL stall_resp: got %0d responses at +%0d, expected one at +9 data %h", rsp_c.size(), rsp_c.size() ? rsp_c[0] - t : -1, ed); end
    checks++; if (hold != 0) begin errors++; $display("FAIL stall_ready_busy: got %0d bad cycles expected 0", hold); end
    checks++; if (stab != 0) begin errors++; $display("FAIL stall_fields: got %0d unstable cycles expected 0", stab); end
    checks++; if (nv != 7) begin errors++; $display("FAIL stall_valid_cycles: got %0d expected 7", nv); end
  endtask

  task automatic test_err();
    int t, lat; bit ee, ew; logic [31:0] ed, ewd;
    logic [3:0]  ops [3] = '{4'd0, 4'd15, 4'd9};
    logic [31:0] adr [3] = '{32'h102, 32'h100, 32'h104};
    for (int k = 0; k < ((LEGAL_MAX == 8) ? 3 : 2); k++) begin
      model_amo(ops[k], adr[k], 32'd7, 0, 0, ee, ed, ew, ewd, lat);
      run_amo(ops[k], adr[k], 32'd7, 0, 0, t);
      checks++; if (rsp_c.size() != 1 || rsp_c[0] != t + 1 || rsp_e[0] !== 1'b1 || rsp_d[0] !== 32'd0) begin
        errors++; $display("FAIL err_resp op%0d addr %h: got %0d responses, expected one at +1 err 1 data 0", ops[k], adr[k], rsp_c.size()); end
      checks++; if (mrv_cnt != 0) begin errors++; $display("FAIL err_no_mem op%0d: got %0d mem_req_valid cycles expected 0", ops[k], mrv_cnt); end
    end
  endtask

  task automatic test_back_to_back();
    int acc[$], lat, rdy_hi = 0; bit ee, ew; logic [31:0] ed0, ed1, ewd;
    logic [31:0] d = $urandom;
    mem[96] = $urandom; ref_mem[96] = mem[96];
    model_amo(4'd0, 32'h180, d, 0, 0, ee, ed0, ew, ewd, lat);
    model_amo(4'd0, 32'h180, d, 0, 0, ee, ed1, ew, ewd, lat);
    clear_logs();
    @(posedge clk); #1;
    bus.req_valid = 1; bus.req_op = 4'd0; bus.req_addr = 32'h180; bus.req_data = d;
    for (int i = 0; i < 30 && acc.size() < 2; i++) begin @(negedge clk); if (bus.req_ready) acc.push_back(cyc); end
    @(posedge clk); #1; bus.req_valid = 0;
    for (int i = 0; i < 20 && rsp_c.size() < 2; i++) begin @(negedge clk); #1; end
    foreach (trace[i]) if (acc.size() == 2 && trace[i].c > acc[0] && trace[i].c < acc[1] && trace[i].rdy) rdy_hi++;
    checks++; if (acc.size() != 2 || acc[1] != acc[0] + 5) begin errors++; $display("FAIL b2b_accept: got %0d accepts spaced %0d expected 2 spaced 5", acc.size(), acc.size() == 2 ? acc[1] - acc[0] : -1); end
    checks++; if (rdy_hi != 0) begin errors++; $display("FAIL b2b_ready_low: got %0d ready cycles expected 0", rdy_hi); end
    checks++; if (rsp_c.size() != 2 || rsp_d[0] !== ed0 || rsp_d[1] !== ed1) begin errors++; $display("FAIL b2b_resp: got %0d responses, expected %h then %h", rsp_c.size(), ed0, ed1); end
  endtask

  task automatic test_reset_mid();
    int t = -1;
    clear_logs(); rsp_delay = 3;
    @(posedge clk); #1;
    bus.req_valid = 1; bus.req_op = 4'd0; bus.req_addr = 32'h1C0; bus.req_data = 32'd9;
    for (int i = 0; i < 20 && t < 0; i++) begin @(negedge clk); if (bus.req_ready) t = cyc; end
    @(posedge clk); #1; bus.req_valid = 0; clear_logs();
    @(posedge clk); #1; arst_n = 0;
    repeat (2) @(posedge clk);
    #1; arst_n = 1; res_v = 0;
    repeat (6) @(negedge clk);
    #1; rsp_delay = 0;
    checks++; if (wr_c.size() != 0) begin errors++; $display("FAIL rstmid_no_write: got %0d writes expected 0", wr_c.size()); end
    checks++; if (rsp_c.size() != 0) begin errors++; $display("FAIL rstmid_no_resp: got %0d responses expected 0", rsp_c.size()); end
    checks++; if ({bus.req_ready, bus.busy} !== 2'b10) begin errors++; $display("FAIL rstmid_idle: ready/busy got %b expected 10", {bus.req_ready, bus.busy}); end
  endtask

`ifdef AMO_CTRL_LRSC_EN
  task automatic test_lrsc();
    int t, lat; bit ee, ew; logic [31:0] ed, ewd;
    model_amo(4'd9, 32'h200, 32'd0, 0, 0, ee, ed, ew, ewd, lat);
    run_amo(4'd9, 32'h200, 32'd0, 0, 0, t);
    checks++; if (rsp_c.size() != 1 || rsp_d[0] !== ed || wr_c.size() != 0) begin errors++; $display("FAIL lr_resp: got %0d responses %0d writes, expected data %h no write", rsp_c.size(), wr_c.size(), ed); end
    model_amo(4'd10, 32'h200, 32'd7, 0, 0, ee, ed, ew, ewd, lat);
    run_amo(4'd10, 32'h200, 32'd7, 0, 0, t);
    checks++; if (wr_c.size() != 1 || wr_a[0] !== 32'h200 || wr_d[0] !== 32'd7) begin errors++; $display("FAIL sc_write: got %0d writes expected 7 to 0x200", wr_c.size()); end
    checks++; if (rsp_c.size() != 1 || rsp_d[0] !== 32'd0) begin errors++; $display("FAIL sc_ok_resp: got %0d responses expected data 0", rsp_c.size()); end
    model_amo(4'd9, 32'h200, 32'd0, 0, 0, ee, ed, ew, ewd, lat);
    run_amo(4'd9, 32'h200, 32'd0, 0, 0, t);
    model_amo(4'd1, 32'h200, 32'd3, 0, 0, ee, ed, ew, ewd, lat);
    run_amo(4'd1, 32'h200, 32'd3, 0, 0, t);
    model_amo(4'd10, 32'h200, 32'd7, 0, 0, ee, ed, ew, ewd, lat);
    run_amo(4'd10, 32'h200, 32'd7, 0, 0, t);
    checks++; if (wr_c.size() != 0 || mrv_cnt != 0) begin errors++; $display("FAIL sc_fail_no_write: got %0d writes expected 0", wr_c.size()); end
    checks++; if (rsp_c.size() != 1 || rsp_d[0] !== 32'd1 || rsp_e[0] !== 1'b0) begin errors++; $display("FAIL sc_fail_resp: got %0d responses expected data 1 err 0", rsp_c.size()); end
  endtask
`endif

  task automatic test_random();
    int t, lat, rs, ws, bad_mem = 0; bit ee, ew; logic [31:0] ed, ewd, a, d;
    logic [3:0] op;
    logic [31:0] pats [4] = '{32'h0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    for (int n = 0; n < 60; n++) begin
      op = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, LEGAL_MAX));
      case ($urandom_range(0, 3))
        0: a = 32'h200;
        1: a = 32'h204;
        2: a = {22'd0, 8'($urandom), 2'b00};
        default: a = {22'd0, 8'($urandom), ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00};
      endcase
      case ($urandom_range(0, 3))
        0: d = pats[$urandom_range(0, 3)];
        1: d = ref_mem[a[9:2]];
        default: d = $urandom;
      endcase
      rs = $urandom_range(0, 2); ws = $urandom_range(0, 2);
      model_amo(op, a, d, rs, ws, ee, ed, ew, ewd, lat);
      run_amo(op, a, d, rs, ws, t);
      checks++; if (rsp_c.size() != 1) begin errors++; $display("FAIL rnd_resp_count #%0d op%0d: got %0d expected 1", n, op, rsp_c.size()); end
      else begin
        checks++; if (rsp_e[0] !== ee || rsp_d[0] !== ed) begin errors++; $display("FAIL rnd_resp #%0d op%0d addr %h: got err %b data %h expected err %b data %h", n, op, a, rsp_e[0], rsp_d[0], ee, ed); end
        checks++; if (rsp_c[0] - t != lat) begin errors++; $display("FAIL rnd_latency #%0d op%0d: got %0d expected %0d", n, op, rsp_c[0] - t, lat); end
      end
      checks++; if (wr_c.size() != int'(ew)) begin errors++; $display("FAIL rnd_write_count #%0d op%0d: got %0d expected %0d", n, op, wr_c.size(), ew); end
      else if (ew) begin
        checks++; if (wr_a[0] !== a || wr_d[0] !== ewd) begin errors++; $display("FAIL rnd_write #%0d op%0d: got %h@%h expected %h@%h", n, op, wr_d[0], wr_a[0], ewd, a); end
      end
      if (ee) begin
        checks++; if (mrv_cnt != 0) begin errors++; $display("FAIL rnd_err_no_mem #%0d: got %0d expected 0", n, mrv_cnt); end
      end
    end
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad_mem++;
    checks++; if (bad_mem != 0) begin errors++; $display("FAIL mem_image: got %0d differing words expected 0", bad_mem); end
  endtask

  initial begin
    bus.req_valid = 0; bus.req_op = '0; bus.req_addr = '0; bus.req_data = '0;
    for (int i = 0; i < 256; i++) begin mem[i] = $urandom; ref_mem[i] = mem[i]; end
    test_reset();
    test_add();
    test_minmax();
    test_stall();
    test_err();
    test_back_to_back();
    test_reset_mid();
`ifdef AMO_CTRL_LRSC_EN
    test_lrsc();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
